// File: rtl/qk_seq_ctrl_pkg.sv
// Shared definitions for the Q/K attention sequencer: state encoding,
// core instruction-word bit positions and default sizing.
package qk_seq_ctrl_pkg;

  // Sequencer phases, in the order a pass walks through them.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_QWR   = 4'd1,
    S_KWR   = 4'd2,
    S_KLOAD = 4'd3,
    S_GAP   = 4'd4,
    S_EXEC  = 4'd5,
    S_WAITF = 4'd6,
    S_ACC   = 4'd7,
    S_DIV   = 4'd8,
    S_PWR   = 4'd9,
    S_DONE  = 4'd10
  } qk_state_e;

  // Core instruction word layout. Bits [21:20] are reserved and stay 0.
  localparam int INST_W        = 22;
  localparam int BIT_PMEM_WR   = 0;
  localparam int BIT_PMEM_RD   = 1;
  localparam int BIT_KMEM_WR   = 2;
  localparam int BIT_KMEM_RD   = 3;
  localparam int BIT_QMEM_WR   = 4;
  localparam int BIT_QMEM_RD   = 5;
  localparam int BIT_LOAD      = 6;
  localparam int BIT_EXECUTE   = 7;
  localparam int PMEM_ADD_LSB  = 8;
  localparam int QKMEM_ADD_LSB = 12;
  localparam int ADD_W         = 4;
  localparam int BIT_OFIFO_RD  = 16;
  localparam int BIT_DIV       = 17;
  localparam int BIT_ACC       = 18;
  localparam int BIT_SFP_PMEM  = 19;

  // Default pass geometry.
  localparam int N_VEC_DEF   = 8;
  localparam int DRAIN_DEF   = 8;
  localparam int TIMEOUT_DEF = 64;

  // One-hot instruction word with a single control bit set.
  function automatic logic [INST_W-1:0] inst_bit(input int pos);
    logic [INST_W-1:0] r;
    r      = '0;
    r[pos] = 1'b1;
    return r;
  endfunction

  // Instruction word carrying only an address field at the given LSB.
  function automatic logic [INST_W-1:0] inst_addr(input int lsb, input logic [ADD_W-1:0] a);
    logic [INST_W-1:0] r;
    r               = '0;
    r[lsb +: ADD_W] = a;
    return r;
  endfunction

endpackage

// File: rtl/qk_seq_ctrl.sv
// Q/K attention pass sequencer. Streams Q then K vectors into the core
// memories, then steps the core through load, drain gap, execute, output
// FIFO wait (with timeout), accumulate, divide and psum write-back.
//
// Input handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready depends only on state (high in QWR/KWR),
// and in_valid is ignored whenever in_ready is low.
//
// inst and mem_in are registered, so the instruction for a phase cycle (or
// for an accepted beat) appears on the port one cycle after that cycle.
module qk_seq_ctrl
  import qk_seq_ctrl_pkg::*;
#(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int n_vec   = N_VEC_DEF,
  parameter int drain   = DRAIN_DEF,
  parameter int timeout = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [pr*bw-1:0]  in_data,
  output logic              in_ready,
  input  logic              fifo_valid,
  output logic [pr*bw-1:0]  mem_in,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output qk_state_e         state_dbg
);

  localparam int DW      = pr * bw;
  localparam int CNT_MAX = (n_vec > drain) ? n_vec : drain;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TW      = (timeout > 1) ? $clog2(timeout) : 1;

  localparam logic [CW-1:0] NV_LAST = CW'(n_vec - 1);
  localparam logic [CW-1:0] DR_LAST = CW'(drain - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(timeout - 1);

  qk_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DW-1:0]     mem_q, mem_d;

  logic              accept;
  logic              nv_last;
  logic [ADD_W-1:0]  addr;

  assign in_ready  = (state_q == S_QWR) || (state_q == S_KWR);
  assign accept    = in_valid && in_ready;
  assign nv_last   = (cnt_q == NV_LAST);
  assign addr      = ADD_W'(cnt_q);

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign inst      = inst_q;
  assign mem_in    = mem_q;
  assign state_dbg = state_q;

  // State, counters, sticky error and registered core-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      inst_q  <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
      mem_q   <= mem_d;
    end
  end

  // Next-state, phase counter and instruction decode for the current cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    inst_d  = '0;
    mem_d   = mem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_QWR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      S_QWR: begin
        if (accept) begin
          inst_d = inst_bit(BIT_QMEM_WR) | inst_addr(QKMEM_ADD_LSB, addr);
          mem_d  = in_data;
          if (nv_last) begin
            state_d = S_KWR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_KWR: begin
        if (accept) begin
          inst_d = inst_bit(BIT_KMEM_WR) | inst_addr(QKMEM_ADD_LSB, addr);
          mem_d  = in_data;
          if (nv_last) begin
            state_d = S_KLOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_KLOAD: begin
        inst_d = inst_bit(BIT_KMEM_RD) | inst_bit(BIT_LOAD)
               | inst_addr(QKMEM_ADD_LSB, addr);
        if (nv_last) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == DR_LAST) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_EXEC: begin
        inst_d = inst_bit(BIT_QMEM_RD) | inst_bit(BIT_EXECUTE)
               | inst_addr(QKMEM_ADD_LSB, addr);
        if (nv_last) begin
          state_d = S_WAITF;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAITF: begin
        if (fifo_valid) begin
          state_d = S_ACC;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else if (tcnt_q == TO_LAST) begin
          // Core never produced a row: abandon the pass without done.
          state_d = S_IDLE;
          cnt_d   = '0;
          tcnt_d  = '0;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      S_ACC: begin
        inst_d = inst_bit(BIT_OFIFO_RD) | inst_bit(BIT_ACC);
        if (nv_last) begin
          state_d = S_DIV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DIV: begin
        inst_d = inst_bit(BIT_DIV) | inst_bit(BIT_SFP_PMEM);
        if (nv_last) begin
          state_d = S_PWR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PWR: begin
        inst_d = inst_bit(BIT_OFIFO_RD) | inst_bit(BIT_PMEM_WR)
               | inst_addr(PMEM_ADD_LSB, addr);
        if (nv_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tcnt_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_qk_seq_ctrl.sv
// Self-checking bench for qk_seq_ctrl. Each pass pushes its full expected
// output schedule (cycle, done, inst, mem_in) into exp_q when it starts; a
// monitor pops and compares whenever inst is non-zero or done is high.
module tb_qk_seq_ctrl;

  localparam int DW = 64;
  localparam int EW = 32 + 1 + 22 + DW;

  // Expected instruction patterns, written out by hand from the bit map.
  localparam logic [21:0] I_QWR  = 22'h000010;  // qmem_wr
  localparam logic [21:0] I_KWR  = 22'h000004;  // kmem_wr
  localparam logic [21:0] I_LOAD = 22'h000048;  // kmem_rd | load
  localparam logic [21:0] I_EXEC = 22'h0000A0;  // qmem_rd | execute
  localparam logic [21:0] I_ACC  = 22'h050000;  // ofifo_rd | acc
  localparam logic [21:0] I_DIV  = 22'h0A0000;  // div | sfp_pmem_wr
  localparam logic [21:0] I_PWR  = 22'h010001;  // ofifo_rd | pmem_wr
  localparam logic [63:0] JUNK   = 64'hDEAD_BEEF_0BAD_F00D;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_EXEC  = 4'd5;
  localparam logic [3:0] ST_WAITF = 4'd6;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          fifo_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] mem_in;
  logic [21:0]   inst;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qk_seq_ctrl dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_valid (fifo_valid),
    .mem_in     (mem_in),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  logic          exp_err = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] vecs[16];

  function automatic logic [EW-1:0] mk(input int c, input logic d, input logic [21:0] i,
                                       input logic [DW-1:0] m);
    return {32'(c), d, i, m};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int cut, input int c, input logic d, input logic [21:0] i,
                         input logic [DW-1:0] m);
    if (c < cut) exp_q.push_back(mk(c, d, i, m));
  endtask

  // Monitor: every cycle with core activity must match the next expected entry.
  always @(negedge clk) begin : monitor
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    if (mon_en && (inst !== 22'd0 || done !== 1'b0)) begin
      got = mk(cyc, done, inst, mem_in);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc %0d done %b inst %h mem_in %h, nothing expected",
                 cyc, done, inst, mem_in);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL output_event: got cyc %0d done %b inst %h mem_in %h, expected cyc %0d done %b inst %h mem_in %h",
                   cyc, done, inst, mem_in, e[EW-1 -: 32], e[DW+22], e[DW +: 22], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One pass from start. toggle_q: in_valid alternates during QWR.
  // fifo_never: fifo_valid stays low (timeout). start_in_kwr: extra start
  // pulse mid-KWR. rst_at >= 0: reset asserted that many cycles after start.
  task automatic run_pass(input bit toggle_q, input bit fifo_never, input bit start_in_kwr,
                          input int rst_at);
    int s, qend, f, cut, last, idx;
    @(posedge clk); #1;
    s    = cyc;
    qend = toggle_q ? s + 16 : s + 9;     // cycle of last Q write on inst
    f    = qend + 35;                     // cycle fifo_valid rises
    cut  = (rst_at >= 0) ? s + rst_at : 32'h7fff_ffff;

    for (int i = 0; i < 8; i++)
      push_ev(cut, toggle_q ? s + 2 + 2 * i : s + 2 + i, 1'b0, I_QWR | (22'(i) << 12), vecs[i]);
    for (int j = 0; j < 8; j++)
      push_ev(cut, qend + 1 + j, 1'b0, I_KWR | (22'(j) << 12), vecs[8 + j]);
    for (int j = 0; j < 8; j++)
      push_ev(cut, qend + 9 + j, 1'b0, I_LOAD | (22'(j) << 12), vecs[15]);
    for (int j = 0; j < 8; j++)
      push_ev(cut, qend + 25 + j, 1'b0, I_EXEC | (22'(j) << 12), vecs[15]);
    if (!fifo_never) begin
      for (int j = 0; j < 8; j++) push_ev(cut, f + 2 + j, 1'b0, I_ACC, vecs[15]);
      for (int j = 0; j < 8; j++) push_ev(cut, f + 10 + j, 1'b0, I_DIV, vecs[15]);
      for (int j = 0; j < 8; j++)
        push_ev(cut, f + 18 + j, (j == 7), I_PWR | (22'(j) << 8), vecs[15]);
    end

    last = fifo_never ? qend + 100 : ((rst_at >= 0) ? s + rst_at + 12 : f + 28);

    for (int c = s; c <= last; c++) begin
      if (c == s) check("err_before_start", 64'(err), 64'(exp_err));
      if (c == s + 1) begin
        check("err_after_start", 64'(err), 64'd0);
        check("in_ready_qwr", 64'(in_ready), 64'd1);
        check("busy_qwr", 64'(busy), 64'd1);
        exp_err = 1'b0;
      end
      if (fifo_never && c == qend + 95) begin
        check("waitf_last_state", 64'(state_dbg), 64'(ST_WAITF));
        check("waitf_last_err", 64'(err), 64'd0);
      end
      if (fifo_never && c == qend + 96) begin
        check("timeout_state", 64'(state_dbg), 64'(ST_IDLE));
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_busy", 64'(busy), 64'd0);
        check("timeout_done", 64'(done), 64'd0);
        exp_err = 1'b1;
      end
      if (fifo_never && c == last) check("err_sticky", 64'(err), 64'd1);
      if (rst_at >= 0 && c == s + rst_at) begin
        check("pre_reset_state", 64'(state_dbg), 64'(ST_EXEC));
        rst_n = 1'b0;
        #1;
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_mem_in", mem_in, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      end
      if (rst_at >= 0 && c == s + rst_at + 2) rst_n = 1'b1;
      if (rst_at >= 0 && c > s + rst_at + 2) begin
        check("post_reset_idle", 64'(state_dbg), 64'(ST_IDLE));
        check("post_reset_busy", 64'(busy), 64'd0);
      end

      start      = (c == s) || (start_in_kwr && c == qend + 3);
      fifo_valid = !fifo_never && rst_at < 0 && c >= f;
      if (c > s && c < qend) begin
        idx = c - s - 1;
        if (toggle_q) begin
          in_valid = (idx % 2 == 0);
          in_data  = in_valid ? vecs[idx / 2] : JUNK;
        end else begin
          in_valid = 1'b1;
          in_data  = vecs[idx];
        end
      end else if (c >= qend && c < qend + 8) begin
        in_valid = 1'b1;
        in_data  = vecs[8 + c - qend];
      end else if (c > s) begin
        in_valid = 1'b1;
        in_data  = JUNK;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    start      = 1'b0;
    in_valid   = 1'b0;
    fifo_valid = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++)
      vecs[i] = 64'h1122_3344_5566_7788 ^ (64'(i + 1) * 64'h0F01_0203_0405_0607);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_inst", 64'(inst), 64'd0);
    check("reset_mem_in", mem_in, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    run_pass(1'b0, 1'b0, 1'b0, -1);  // clean pass
    run_pass(1'b1, 1'b0, 1'b0, -1);  // in_valid toggling during QWR
    run_pass(1'b0, 1'b0, 1'b1, -1);  // stray start during KWR
    run_pass(1'b0, 1'b1, 1'b0, -1);  // fifo never valid: timeout
    run_pass(1'b0, 1'b0, 1'b0, -1);  // next start clears err
    run_pass(1'b0, 1'b0, 1'b0, 37);  // reset during EXEC cnt=4
    run_pass(1'b0, 1'b0, 1'b0, -1);  // full pass after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d, limit 20000", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qk_seq_ctrl.md
QK_SEQ_CTRL -- requirements
Module: qk_seq_ctrl

Interface
REQ-001 Parameter bw, default 8: bits per element.
REQ-002 Parameter pr, default 8: elements per vector; mem_in width is pr*bw.
REQ-003 Parameter n_vec, default 8: vectors per Q and K load, and rows per readout phase.
REQ-004 Parameter drain, default 8: idle cycles between KLOAD and EXEC.
REQ-005 Parameter timeout, default 64: maximum WAITF cycles before error.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port start, input, 1: begin one Q/K attention pass; sampled only in IDLE.
REQ-009 Port in_valid, input, 1: in_data holds a valid vector.
REQ-010 Port in_data, input, pr*bw: Q vectors first, then K vectors.
REQ-011 Port in_ready, output, 1: the block accepts in_data this cycle.
REQ-012 Port fifo_valid, input, 1: the core output FIFO holds a complete row.
REQ-013 Port mem_in, output, pr*bw: registered write data to the core Q/K memories.
REQ-014 Port inst, output, 22: registered core instruction word.
REQ-015 Port busy, output, 1: high whenever state is not IDLE.
REQ-016 Port done, output, 1: one-cycle pulse at the end of a successful pass.
REQ-017 Port err, output, 1: sticky WAITF-timeout flag; cleared by the next accepted start.

Function
REQ-018 inst bit map: [0] pmem_wr, [1] pmem_rd, [2] kmem_wr, [3] kmem_rd, [4] qmem_wr, [5] qmem_rd, [6] load, [7] execute, [11:8] pmem_add, [15:12] qkmem_add, [16] ofifo_rd, [17] div, [18] acc, [19] sfp_pmem_wr; [21:20] are always 0.
REQ-019 Address fields shall carry the phase counter cnt (0..n_vec-1), zero-extended.
REQ-020 States: IDLE, QWR, KWR, KLOAD, GAP, EXEC, WAITF, ACC, DIV, PWR, DONE.
REQ-021 In IDLE, inst=0 and in_ready=0; start=1 moves to QWR with cnt=0 and clears err.
REQ-022 In QWR/KWR, in_ready=1; a beat is accepted when in_valid&in_ready.
REQ-023 An accepted beat drives, in the next cycle, mem_in=in_data, inst[15:12]=cnt and inst[4] (QWR) or inst[2] (KWR); cnt then increments. Cycles with no accepted beat drive inst=0 and hold mem_in.
REQ-024 After beat n_vec-1, QWR moves to KWR and KWR moves to KLOAD, with cnt reset to 0 on each transition.
REQ-025 KLOAD lasts n_vec cycles with inst[3]=1, inst[6]=1, inst[15:12]=cnt; it then moves to GAP.
REQ-026 GAP lasts drain cycles with inst=0; it then moves to EXEC.
REQ-027 EXEC lasts n_vec cycles with inst[5]=1, inst[7]=1, inst[15:12]=cnt; it then moves to WAITF.
REQ-028 WAITF drives inst=0 until fifo_valid=1, then moves to ACC.
REQ-029 If WAITF reaches timeout cycles, the block shall set err and return to IDLE without pulsing done.
REQ-030 ACC lasts n_vec cycles with inst[16]=1, inst[18]=1.
REQ-031 DIV lasts n_vec cycles with inst[17]=1, inst[19]=1.
REQ-032 PWR lasts n_vec cycles with inst[16]=1, inst[0]=1, inst[11:8]=cnt.
REQ-033 DONE lasts one cycle with done=1 and inst=0, then returns to IDLE.
REQ-034 start outside IDLE shall be ignored, and in_valid outside QWR/KWR shall be ignored.
REQ-035 cnt wraps to 0 on every state change and never exceeds n_vec-1 (or drain-1 in GAP).

Reset
REQ-036 reset low shall immediately force state=IDLE, cnt=0, inst=0, mem_in=0, in_ready=0, busy=0, done=0 and err=0, including mid-pass; no partial sequence resumes after release.

Structure
REQ-037 A shared package shall hold the state enum, the inst bit-position and field constants, and the defaults for n_vec and drain.
REQ-038 There is a single module with no sub-module; cnt and the timeout counter are inline registers.

Verification
REQ-039 Pass with in_valid held high and fifo_valid rising 3 cycles after EXEC: 8 qmem_wr beats at addresses 0..7, then 8 kmem_wr beats, then 8 load, 8 idle, 8 execute, 8 acc, 8 div and 8 pmem_wr cycles at pmem_add 0..7, then done=1 for exactly 1 cycle.
REQ-040 in_valid toggled every other cycle in QWR: exactly 8 writes with mem_in matching vectors 0..7 in order, and inst=0 on the gap cycles.
REQ-041 fifo_valid held low: err=1 after 64 WAITF cycles, state returns to IDLE, done stays 0; the next start clears err.
REQ-042 reset driven low during EXEC cnt=4: all outputs are 0 immediately, and after release the block stays in IDLE until start.
REQ-043 start pulsed during KWR: no effect, and the pass completes in the same cycle count as the clean run.
